// File: rtl/usb3_tx_hdr_pkg.sv
// Shared definitions for the USB3 TX header arbiter: TP/DPH field layouts,
// grant encodings and the arbiter state type.
package usb3_tx_hdr_pkg;

   // TP field layout, MSB first: retry, dir, subtype, endp, nump, seq, stream
   localparam int TP_FIELDS_W    = 36;
   localparam int TP_STREAM_LSB  = 0;   // [15:0]
   localparam int TP_SEQ_LSB     = 16;  // [20:16]
   localparam int TP_NUMP_LSB    = 21;  // [25:21]
   localparam int TP_ENDP_LSB    = 26;  // [29:26]
   localparam int TP_SUBTYPE_LSB = 30;  // [33:30]
   localparam int TP_DIR_BIT     = 34;
   localparam int TP_RETRY_BIT   = 35;

   // DPH field layout, MSB first: eob, dir, endp, seq, len
   localparam int DPH_FIELDS_W   = 27;
   localparam int DPH_LEN_LSB    = 0;   // [15:0]
   localparam int DPH_SEQ_LSB    = 16;  // [20:16]
   localparam int DPH_ENDP_LSB   = 21;  // [24:21]
   localparam int DPH_DIR_BIT    = 25;
   localparam int DPH_EOB_BIT    = 26;

   localparam logic [1:0] GNT_A   = 2'd0;
   localparam logic [1:0] GNT_B   = 2'd1;
   localparam logic [1:0] GNT_C   = 2'd2;
   localparam logic [1:0] GNT_DPH = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DPP   = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/usb3_rr_pick4.sv
// Combinational 4-way round-robin picker.
//   req    : request vector (bit index = requester id)
//   rr     : round-robin pointer; search starts here and wraps upward
//   onehot : one-hot grant (zero when no request)
//   idx    : index of the granted requester (meaningful when any=1)
//   any    : at least one request present
module usb3_rr_pick4 (
   input  logic [3:0] req,
   input  logic [1:0] rr,
   output logic [3:0] onehot,
   output logic [1:0] idx,
   output logic       any
);

   logic [3:0] rot;
   logic [1:0] off;

   always_comb begin
      // rotate so the pointer position lands at bit 0
      rot = 4'({req, req} >> rr);
      off = 2'd0;
      // descending scan leaves the lowest set offset in off
      for (int i = 3; i >= 0; i--) begin
         if (rot[i]) off = 2'(i);
      end
      idx    = rr + off;
      any    = |req;
      onehot = any ? (4'b0001 << idx) : 4'b0000;
   end

endmodule

// File: rtl/usb3_tx_hdr_arbiter.sv
// Round-robin arbiter sharing the link header TX port between TP channels
// A/B/C and the DPH channel. Holds the grant through header acceptance and,
// for DPH, until the DPP completes. A watchdog aborts unserviced grants.
//   clk, reset       : clock, synchronous active-high reset
//   tp_req/tp_fields : TP channel requests (level) and packed fields
//   tp_ack           : per-channel pulse when its TP was accepted
//   dph_req/fields   : DPH request (level) and packed fields
//   dph_ack/dph_done : DPH accepted / DPP finished pulses
//   link_hdr_*       : registered header request to the link
//   link_hdr_ack     : link accepted the header
//   link_dpp_done    : link finished the DPP
//   timeout_err      : pulse on watchdog abort
//   grant_id         : current/last grantee (0=A,1=B,2=C,3=DPH)
module usb3_tx_hdr_arbiter
   import usb3_tx_hdr_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1023,
   parameter int CNT_W          = 10
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [2:0]                  tp_req,
   input  logic [2:0][TP_FIELDS_W-1:0] tp_fields,
   output logic [2:0]                  tp_ack,
   input  logic                        dph_req,
   input  logic [DPH_FIELDS_W-1:0]     dph_fields,
   output logic                        dph_ack,
   output logic                        dph_done,
   output logic                        link_hdr_valid,
   output logic                        link_hdr_is_dph,
   output logic [TP_FIELDS_W-1:0]      link_hdr_fields,
   input  logic                        link_hdr_ack,
   input  logic                        link_dpp_done,
   output logic                        timeout_err,
   output logic [1:0]                  grant_id
);

   arb_state_t             state;
   logic [1:0]             rr;
   logic [CNT_W-1:0]       wd_cnt;
   logic                   wd_hit;
   logic [3:0]             pick_onehot;
   logic [1:0]             pick_idx;
   logic                   pick_any;
   logic [TP_FIELDS_W-1:0] pick_fields;

   usb3_rr_pick4 u_pick (
      .req    ({dph_req, tp_req}),
      .rr     (rr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   // The counter is at TIMEOUT_CYCLES-1 during the last allowed cycle, so
   // the abort lands exactly TIMEOUT_CYCLES cycles after entering the state.
   assign wd_hit = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      pick_fields = tp_fields[pick_onehot[2] ? 2 : (pick_onehot[1] ? 1 : 0)];
      if (pick_idx == GNT_DPH)
         pick_fields = {{(TP_FIELDS_W-DPH_FIELDS_W){1'b0}}, dph_fields};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= ST_IDLE;
         rr              <= 2'd0;
         wd_cnt          <= '0;
         grant_id        <= 2'd0;
         link_hdr_valid  <= 1'b0;
         link_hdr_is_dph <= 1'b0;
         link_hdr_fields <= '0;
         tp_ack          <= 3'b000;
         dph_ack         <= 1'b0;
         dph_done        <= 1'b0;
         timeout_err     <= 1'b0;
      end else begin
         tp_ack      <= 3'b000;
         dph_ack     <= 1'b0;
         dph_done    <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  grant_id        <= pick_idx;
                  link_hdr_is_dph <= (pick_idx == GNT_DPH);
                  link_hdr_fields <= pick_fields;
                  link_hdr_valid  <= 1'b1;
                  wd_cnt          <= '0;
                  state           <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // an ack in the same cycle as the watchdog limit still wins
               if (link_hdr_ack) begin
                  link_hdr_valid <= 1'b0;
                  if (grant_id == GNT_DPH) begin
                     dph_ack <= 1'b1;
                     wd_cnt  <= '0;
                     state   <= ST_DPP;
                  end else begin
                     tp_ack <= 3'b001 << grant_id;
                     state  <= ST_DONE;
                  end
               end else if (wd_hit) begin
                  timeout_err    <= 1'b1;
                  link_hdr_valid <= 1'b0;
                  rr             <= grant_id + 2'd1;
                  state          <= ST_IDLE;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            ST_DPP: begin
               if (link_dpp_done) begin
                  dph_done <= 1'b1;
                  state    <= ST_DONE;
               end else if (wd_hit) begin
                  timeout_err <= 1'b1;
                  rr          <= grant_id + 2'd1;
                  state       <= ST_IDLE;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               // requests are not sampled here; the requester drops req
               // after seeing its ack/done
               rr    <= grant_id + 2'd1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_usb3_tx_hdr_arbiter.sv
module tb_usb3_tx_hdr_arbiter;
   import usb3_tx_hdr_pkg::*;

   localparam int TO = 24;

   logic                        clk;
   logic                        reset;
   logic [2:0]                  tp_req;
   logic [2:0][TP_FIELDS_W-1:0] tp_fields;
   logic [2:0]                  tp_ack;
   logic                        dph_req;
   logic [DPH_FIELDS_W-1:0]     dph_fields;
   logic                        dph_ack;
   logic                        dph_done;
   logic                        link_hdr_valid;
   logic                        link_hdr_is_dph;
   logic [TP_FIELDS_W-1:0]      link_hdr_fields;
   logic                        link_hdr_ack;
   logic                        link_dpp_done;
   logic                        timeout_err;
   logic [1:0]                  grant_id;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] sb_q[$];
   logic [7:0] mon_code;
   logic [7:0] mon_exp;
   logic       flag;
   int         order[5] = '{0, 1, 2, 3, 0};

   usb3_tx_hdr_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
      .clk             (clk),
      .reset           (reset),
      .tp_req          (tp_req),
      .tp_fields       (tp_fields),
      .tp_ack          (tp_ack),
      .dph_req         (dph_req),
      .dph_fields      (dph_fields),
      .dph_ack         (dph_ack),
      .dph_done        (dph_done),
      .link_hdr_valid  (link_hdr_valid),
      .link_hdr_is_dph (link_hdr_is_dph),
      .link_hdr_fields (link_hdr_fields),
      .link_hdr_ack    (link_hdr_ack),
      .link_dpp_done   (link_dpp_done),
      .timeout_err     (timeout_err),
      .grant_id        (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // event codes: {tp_ack[2:0], dph_ack, dph_done, timeout_err, grant_id}
   function automatic logic [7:0] ev_tp(input int i);
      logic [2:0] a;
      a = 3'b001 << i;
      return {a, 3'b000, 2'(i)};
   endfunction
   localparam logic [7:0] EV_DPH_ACK  = 8'b000_100_11;
   localparam logic [7:0] EV_DPH_DONE = 8'b000_010_11;
   function automatic logic [7:0] ev_to(input logic [1:0] g);
      return {6'b000_001, g};
   endfunction

   // scoreboard: every pulse seen must match the next expected event
   always @(negedge clk) begin
      if (!reset) begin
         mon_code = {tp_ack, dph_ack, dph_done, timeout_err, grant_id};
         if (|mon_code[7:2]) begin
            if (sb_q.size() == 0) begin
               chk("unexp_evt", 64'(mon_code), 64'd0);
            end else begin
               mon_exp = sb_q.pop_front();
               chk("evt", 64'(mon_code), 64'(mon_exp));
            end
         end
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      do begin
         cyc();
         n++;
      end while (!link_hdr_valid && n < 16);
      chk(tag, 64'(link_hdr_valid), 64'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tp_req = 3'b000; dph_req = 1'b0;
      link_hdr_ack = 1'b0; link_dpp_done = 1'b0;
      repeat (2) cyc();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got=hang exp=finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      tp_req = 3'b000; dph_req = 1'b0;
      link_hdr_ack = 1'b0; link_dpp_done = 1'b0;
      for (int i = 0; i < 3; i++) tp_fields[i] = {4'($urandom()), 32'($urandom())};
      dph_fields = '0;
      repeat (3) cyc();

      // reset state
      chk("rst_valid", 64'(link_hdr_valid), 0);
      chk("rst_isdph", 64'(link_hdr_is_dph), 0);
      chk("rst_gid", 64'(grant_id), 0);
      chk("rst_pulses", 64'({tp_ack, dph_ack, dph_done, timeout_err}), 0);
      chk("rst_fields", 64'(link_hdr_fields), 0);

      // single TP on A: req at cycle 0, ack at cycle 3
      reset = 1'b0;
      tp_fields[0][15:0] = 16'h1234;
      tp_req = 3'b001;
      cyc();
      chk("t1_valid", 64'(link_hdr_valid), 1);
      chk("t1_isdph", 64'(link_hdr_is_dph), 0);
      chk("t1_fields", 64'(link_hdr_fields), 64'(tp_fields[0]));
      chk("t1_stream", 64'(link_hdr_fields[15:0]), 64'h1234);
      chk("t1_gid", 64'(grant_id), 0);
      cyc();
      cyc();
      chk("t1_valid_c3", 64'(link_hdr_valid), 1);
      link_hdr_ack = 1'b1;
      sb_q.push_back(ev_tp(0));
      cyc();
      link_hdr_ack = 1'b0;
      chk("t1_ack", 64'(tp_ack), 64'b001);
      chk("t1_valid_c4", 64'(link_hdr_valid), 0);
      tp_req = 3'b000;
      cyc();
      chk("t1_ack_clr", 64'(tp_ack), 0);
      cyc();
      chk("t1_no_regrant", 64'(link_hdr_valid), 0);

      // fairness with all requesting and immediate link response
      do_reset();
      tp_req = 3'b111; dph_req = 1'b1;
      link_hdr_ack = 1'b1; link_dpp_done = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_valid("fair_v");
         chk("fair_gid", 64'(grant_id), 64'(order[k]));
         chk("fair_isdph", 64'(link_hdr_is_dph), 64'(order[k] == 3));
         if (order[k] == 3) begin
            sb_q.push_back(EV_DPH_ACK);
            sb_q.push_back(EV_DPH_DONE);
         end else begin
            sb_q.push_back(ev_tp(order[k]));
         end
      end
      tp_req = 3'b000; dph_req = 1'b0;
      cyc();
      link_hdr_ack = 1'b0; link_dpp_done = 1'b0;
      repeat (2) cyc();

      // DPH flow, TP B waiting during the DPP
      dph_fields = {1'b1, 1'b0, 4'h5, 5'd7, 16'd1024};
      dph_req = 1'b1;
      wait_valid("dph_v");
      chk("dph_isdph", 64'(link_hdr_is_dph), 1);
      chk("dph_gid", 64'(grant_id), 3);
      chk("dph_fields", 64'(link_hdr_fields), 64'(dph_fields));
      link_hdr_ack = 1'b1;
      sb_q.push_back(EV_DPH_ACK);
      cyc();
      link_hdr_ack = 1'b0;
      chk("dph_ack", 64'(dph_ack), 1);
      chk("dph_valid_low", 64'(link_hdr_valid), 0);
      dph_req = 1'b0;
      tp_req = 3'b010;
      flag = 1'b0;
      for (int i = 0; i < 19; i++) begin
         cyc();
         flag = flag | link_hdr_valid | (|tp_ack);
      end
      chk("dpp_hold", 64'(flag), 0);
      link_dpp_done = 1'b1;
      sb_q.push_back(EV_DPH_DONE);
      cyc();
      link_dpp_done = 1'b0;
      chk("dph_done", 64'(dph_done), 1);
      wait_valid("after_dpp_v");
      chk("after_dpp_gid", 64'(grant_id), 1);
      link_hdr_ack = 1'b1;
      sb_q.push_back(ev_tp(1));
      tp_req = 3'b000;
      cyc();
      link_hdr_ack = 1'b0;
      repeat (2) cyc();

      // watchdog: B never acked, then C and B re-arbitrated
      tp_req = 3'b010;
      wait_valid("to_v");
      chk("to_gid", 64'(grant_id), 1);
      flag = 1'b0;
      for (int i = 0; i < TO - 1; i++) begin
         cyc();
         flag = flag | ~link_hdr_valid;
      end
      chk("to_valid_held", 64'(flag), 0);
      tp_req = 3'b110;
      sb_q.push_back(ev_to(2'd1));
      cyc();
      chk("to_err", 64'(timeout_err), 1);
      chk("to_valid_drop", 64'(link_hdr_valid), 0);
      chk("to_no_ack", 64'(tp_ack), 0);
      wait_valid("to_c_v");
      chk("to_next_c", 64'(grant_id), 2);
      link_hdr_ack = 1'b1;
      sb_q.push_back(ev_tp(2));
      tp_req = 3'b010;
      cyc();
      link_hdr_ack = 1'b0;
      wait_valid("to_b_v");
      chk("to_then_b", 64'(grant_id), 1);
      link_hdr_ack = 1'b1;
      sb_q.push_back(ev_tp(1));
      tp_req = 3'b000;
      cyc();
      link_hdr_ack = 1'b0;
      repeat (2) cyc();

      // spurious link inputs
      link_hdr_ack = 1'b1;
      flag = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         flag = flag | link_hdr_valid;
      end
      link_hdr_ack = 1'b0;
      chk("spur_ack_idle", 64'(flag), 0);
      tp_req = 3'b001;
      link_dpp_done = 1'b1;
      wait_valid("spur_v");
      flag = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         flag = flag | ~link_hdr_valid | (|tp_ack);
      end
      chk("spur_dpp_issue", 64'(flag), 0);
      link_dpp_done = 1'b0;
      link_hdr_ack = 1'b1;
      sb_q.push_back(ev_tp(0));
      tp_req = 3'b000;
      cyc();
      link_hdr_ack = 1'b0;
      chk("spur_ack", 64'(tp_ack), 64'b001);
      cyc();

      // reset while in DPP, then normal grant for C
      dph_req = 1'b1;
      wait_valid("rdpp_v");
      link_hdr_ack = 1'b1;
      sb_q.push_back(EV_DPH_ACK);
      cyc();
      link_hdr_ack = 1'b0;
      dph_req = 1'b0;
      cyc();
      reset = 1'b1;
      cyc();
      chk("rdpp_valid", 64'(link_hdr_valid), 0);
      chk("rdpp_gid", 64'(grant_id), 0);
      chk("rdpp_pulses", 64'({tp_ack, dph_ack, dph_done, timeout_err}), 0);
      chk("rdpp_fields", 64'(link_hdr_fields), 0);
      reset = 1'b0;
      tp_req = 3'b100;
      wait_valid("rdpp_c_v");
      chk("rdpp_c_gid", 64'(grant_id), 2);
      link_hdr_ack = 1'b1;
      sb_q.push_back(ev_tp(2));
      tp_req = 3'b000;
      cyc();
      link_hdr_ack = 1'b0;
      repeat (3) cyc();

      chk("sb_empty", 64'(sb_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
